mem_port_arbiter: RTL and testbench

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/mem_port_arbiter.sv | 153 +++++++++++++++
 tb/tb_mem_port_arbiter.sv | 344 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Fetch/data arbiter in front of one single-port synchronous memory: issue cycle, then response
// cycle. Define ARB_ROUND_ROBIN_EN to alternate priority on simultaneous requests.
module mem_port_arbiter #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned BE_W   = DATA_W / 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_ack,
  output logic [DATA_W-1:0] i_rdata,
  output logic              i_stall,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  input  logic [BE_W-1:0]   d_be,
  output logic              d_ack,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_stall,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [BE_W-1:0]   mem_be,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam logic [2:0] StIdle   = 3'd0;
  localparam logic [2:0] StIssueI = 3'd1;
  localparam logic [2:0] StIssueD = 3'd2;
  localparam logic [2:0] StRespI  = 3'd3;
  localparam logic [2:0] StRespD  = 3'd4;

  logic [2:0]        state_q, state_d;
  logic              in_decide;
  logic              i_elig, d_elig;
  logic              grant_i, grant_d;

  logic              mem_en_q, mem_en_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [BE_W-1:0]   mem_be_q, mem_be_d;

  // In a response state the owner's request is still its held, now-acked request, so it is
  // masked out of that decision; the other requester can be granted with no idle gap.
  always_comb begin
    in_decide = (state_q == StIdle) || (state_q == StRespI) || (state_q == StRespD);
    i_elig    = in_decide && i_req && (state_q != StRespI);
    d_elig    = in_decide && d_req && (state_q != StRespD);
  end

`ifdef ARB_ROUND_ROBIN_EN
  logic last_d_q, last_d_d;

  // last_d_q = 1 when the most recent grant went to data; reset value favours data first.
  always_comb begin
    grant_d  = d_elig && (!i_elig || !last_d_q);
    grant_i  = i_elig && !grant_d;
    last_d_d = last_d_q;
    if (grant_d) begin
      last_d_d = 1'b1;
    end else if (grant_i) begin
      last_d_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_d_q <= 1'b0;
    end else begin
      last_d_q <= last_d_d;
    end
  end
`else
  always_comb begin
    grant_d = d_elig;
    grant_i = i_elig && !d_elig;
  end
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIssueI: state_d = StRespI;
      StIssueD: state_d = StRespD;
      StIdle, StRespI, StRespD: begin
        if (grant_d) begin
          state_d = StIssueD;
        end else if (grant_i) begin
          state_d = StIssueI;
        end else begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Memory port registers load only on a grant; mem_en/mem_we self-clear after the issue cycle.
  always_comb begin
    mem_en_d    = grant_d || grant_i;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_be_d    = mem_be_q;
    if (grant_d) begin
      mem_we_d    = d_we;
      mem_addr_d  = d_addr;
      mem_wdata_d = d_wdata;
      mem_be_d    = d_be;
    end else if (grant_i) begin
      mem_addr_d = i_addr;
      mem_be_d   = {BE_W{1'b1}};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_be_q    <= '0;
    end else begin
      state_q     <= state_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_be_q    <= mem_be_d;
    end
  end

  always_comb begin
    i_ack     = (state_q == StRespI);
    d_ack     = (state_q == StRespD);
    i_rdata   = i_ack ? mem_rdata : '0;
    d_rdata   = d_ack ? mem_rdata : '0;
    i_stall   = i_req && !i_ack;
    d_stall   = d_req && !d_ack;
    mem_en    = mem_en_q;
    mem_we    = mem_we_q;
    mem_addr  = mem_addr_q;
    mem_wdata = mem_wdata_q;
    mem_be    = mem_be_q;
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter (default build) with a behavioural single-port memory.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        i_req = 1'b0;
  logic [31:0] i_addr = '0;
  logic        i_ack;
  logic [31:0] i_rdata;
  logic        i_stall;
  logic        d_req = 1'b0;
  logic        d_we = 1'b0;
  logic [31:0] d_addr = '0;
  logic [31:0] d_wdata = '0;
  logic [3:0]  d_be = '0;
  logic        d_ack;
  logic [31:0] d_rdata;
  logic        d_stall;
  logic        mem_en;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic [31:0] mem_rdata = '0;

  logic [31:0] mem [0:255];

  int n_cmp  = 0;
  int n_fail = 0;

  mem_port_arbiter dut (
    .clk       (clk),
    .rst       (rst),
    .i_req     (i_req),
    .i_addr    (i_addr),
    .i_ack     (i_ack),
    .i_rdata   (i_rdata),
    .i_stall   (i_stall),
    .d_req     (d_req),
    .d_we      (d_we),
    .d_addr    (d_addr),
    .d_wdata   (d_wdata),
    .d_be      (d_be),
    .d_ack     (d_ack),
    .d_rdata   (d_rdata),
    .d_stall   (d_stall),
    .mem_en    (mem_en),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_be    (mem_be),
    .mem_rdata (mem_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) begin
        for (int b = 0; b < 4; b++) begin
          if (mem_be[b]) mem[mem_addr[9:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
        end
      end else begin
        mem_rdata <= mem[mem_addr[9:2]];
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    i_req = 1'b1;
    i_addr = 32'h10;
    tick();
    tick();
    n_cmp++;
    if ({mem_en, mem_we, mem_addr, mem_wdata, mem_be} !== 70'h0) begin
      n_fail++;
      $display("FAIL reset_mem_port: got en=%b we=%b addr=%h wdata=%h be=%h want all zero",
               mem_en, mem_we, mem_addr, mem_wdata, mem_be);
    end
    n_cmp++;
    if ({i_ack, d_ack, i_stall, d_stall} !== 4'b0010) begin
      n_fail++;
      $display("FAIL reset_ack_stall: got {i_ack,d_ack,i_stall,d_stall}=%b want 0010",
               {i_ack, d_ack, i_stall, d_stall});
    end
    n_cmp++;
    if ({i_rdata, d_rdata} !== 64'h0) begin
      n_fail++;
      $display("FAIL reset_rdata: got i=%h d=%h want 0", i_rdata, d_rdata);
    end
    i_req = 1'b0;
    rst = 1'b0;
    tick();
    n_cmp++;
    if (mem_en !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_no_spurious_grant: got mem_en=%b want 0", mem_en);
    end
  endtask

  task automatic test_fetch();
    i_req = 1'b1;
    i_addr = 32'h10;
    tick();
    n_cmp++;
    if ({mem_en, mem_we, mem_addr, mem_be} !== {1'b1, 1'b0, 32'h10, 4'hF}) begin
      n_fail++;
      $display("FAIL fetch_issue: got en=%b we=%b addr=%h be=%h want 1 0 00000010 f",
               mem_en, mem_we, mem_addr, mem_be);
    end
    n_cmp++;
    if ({i_ack, i_stall, i_rdata} !== {1'b0, 1'b1, 32'h0}) begin
      n_fail++;
      $display("FAIL fetch_issue_ack: got ack=%b stall=%b rdata=%h want 0 1 0",
               i_ack, i_stall, i_rdata);
    end
    tick();
    n_cmp++;
    if ({i_ack, i_stall, i_rdata, mem_en} !== {1'b1, 1'b0, 32'hDEADBEEF, 1'b0}) begin
      n_fail++;
      $display("FAIL fetch_resp: got ack=%b stall=%b rdata=%h en=%b want 1 0 deadbeef 0",
               i_ack, i_stall, i_rdata, mem_en);
    end
    i_req = 1'b0;
    tick();
    n_cmp++;
    if ({i_ack, i_rdata, mem_en} !== {1'b0, 32'h0, 1'b0}) begin
      n_fail++;
      $display("FAIL fetch_after: got ack=%b rdata=%h en=%b want 0 0 0", i_ack, i_rdata, mem_en);
    end
  endtask

  task automatic test_simultaneous();
    i_req = 1'b1;
    i_addr = 32'h20;
    d_req = 1'b1;
    d_we = 1'b0;
    d_addr = 32'h100;
    tick();
    n_cmp++;
    if ({mem_en, mem_we, mem_addr} !== {1'b1, 1'b0, 32'h100}) begin
      n_fail++;
      $display("FAIL simul_data_first: got en=%b we=%b addr=%h want 1 0 00000100",
               mem_en, mem_we, mem_addr);
    end
    tick();
    n_cmp++;
    if ({d_ack, d_rdata, i_ack} !== {1'b1, 32'hCAFE0100, 1'b0}) begin
      n_fail++;
      $display("FAIL simul_d_ack: got d_ack=%b d_rdata=%h i_ack=%b want 1 cafe0100 0",
               d_ack, d_rdata, i_ack);
    end
    d_req = 1'b0;
    tick();
    n_cmp++;
    if ({mem_en, mem_addr, mem_be, d_ack} !== {1'b1, 32'h20, 4'hF, 1'b0}) begin
      n_fail++;
      $display("FAIL simul_fetch_issue: got en=%b addr=%h be=%h d_ack=%b want 1 00000020 f 0",
               mem_en, mem_addr, mem_be, d_ack);
    end
    tick();
    n_cmp++;
    if ({i_ack, i_rdata, d_ack} !== {1'b1, 32'hA5A50020, 1'b0}) begin
      n_fail++;
      $display("FAIL simul_i_ack: got i_ack=%b i_rdata=%h d_ack=%b want 1 a5a50020 0",
               i_ack, i_rdata, d_ack);
    end
    i_req = 1'b0;
    tick();
  endtask

  task automatic test_write();
    d_req = 1'b1;
    d_we = 1'b1;
    d_addr = 32'h40;
    d_wdata = 32'h12345678;
    d_be = 4'b0011;
    tick();
    n_cmp++;
    if ({mem_en, mem_we, mem_addr, mem_wdata, mem_be}
        !== {1'b1, 1'b1, 32'h40, 32'h12345678, 4'b0011}) begin
      n_fail++;
      $display("FAIL write_issue: got en=%b we=%b addr=%h wdata=%h be=%b want 1 1 40 12345678 0011",
               mem_en, mem_we, mem_addr, mem_wdata, mem_be);
    end
    tick();
    n_cmp++;
    if ({d_ack, mem_we} !== 2'b10) begin
      n_fail++;
      $display("FAIL write_ack: got d_ack=%b mem_we=%b want 1 0", d_ack, mem_we);
    end
    d_req = 1'b0;
    d_we = 1'b0;
    d_be = 4'b0000;
    tick();
    d_req = 1'b1;
    tick();
    n_cmp++;
    if ({mem_en, mem_we, mem_addr} !== {1'b1, 1'b0, 32'h40}) begin
      n_fail++;
      $display("FAIL readback_issue: got en=%b we=%b addr=%h want 1 0 00000040",
               mem_en, mem_we, mem_addr);
    end
    tick();
    n_cmp++;
    if ({d_ack, d_rdata} !== {1'b1, 32'hFFFF5678}) begin
      n_fail++;
      $display("FAIL readback_data: got ack=%b rdata=%h want 1 ffff5678", d_ack, d_rdata);
    end
    d_req = 1'b0;
    tick();
  endtask

  task automatic test_drop_and_wait();
    i_req = 1'b1;
    i_addr = 32'h10;
    tick();
    // Fetch drops right after grant; data arrives during the issue cycle and must wait.
    i_req = 1'b0;
    d_req = 1'b1;
    d_addr = 32'h100;
    tick();
    n_cmp++;
    if ({i_ack, i_rdata, mem_en, d_ack} !== {1'b1, 32'hDEADBEEF, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL drop_ack: got i_ack=%b i_rdata=%h en=%b d_ack=%b want 1 deadbeef 0 0",
               i_ack, i_rdata, mem_en, d_ack);
    end
    tick();
    n_cmp++;
    if ({mem_en, mem_addr, i_ack} !== {1'b1, 32'h100, 1'b0}) begin
      n_fail++;
      $display("FAIL wait_issue: got en=%b addr=%h i_ack=%b want 1 00000100 0",
               mem_en, mem_addr, i_ack);
    end
    tick();
    n_cmp++;
    if ({d_ack, d_rdata} !== {1'b1, 32'hCAFE0100}) begin
      n_fail++;
      $display("FAIL wait_ack: got ack=%b rdata=%h want 1 cafe0100", d_ack, d_rdata);
    end
    d_req = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid();
    d_req = 1'b1;
    d_addr = 32'h100;
    tick();
    n_cmp++;
    if (mem_en !== 1'b1) begin
      n_fail++;
      $display("FAIL rmid_issue: got mem_en=%b want 1", mem_en);
    end
    rst = 1'b1;
    tick();
    n_cmp++;
    if ({d_ack, mem_en, mem_addr, d_rdata} !== {1'b0, 1'b0, 32'h0, 32'h0}) begin
      n_fail++;
      $display("FAIL rmid_abandon: got d_ack=%b en=%b addr=%h rdata=%h want 0 0 0 0",
               d_ack, mem_en, mem_addr, d_rdata);
    end
    rst = 1'b0;
    tick();
    n_cmp++;
    if ({mem_en, mem_addr, d_ack} !== {1'b1, 32'h100, 1'b0}) begin
      n_fail++;
      $display("FAIL rmid_retry_issue: got en=%b addr=%h d_ack=%b want 1 00000100 0",
               mem_en, mem_addr, d_ack);
    end
    tick();
    n_cmp++;
    if ({d_ack, d_rdata} !== {1'b1, 32'hCAFE0100}) begin
      n_fail++;
      $display("FAIL rmid_retry_ack: got ack=%b rdata=%h want 1 cafe0100", d_ack, d_rdata);
    end
    d_req = 1'b0;
    tick();
  endtask

  task automatic test_back_to_back();
    logic [7:0]  exp_en;
    logic [7:0]  exp_dack;
    logic [7:0]  exp_iack;
    logic [31:0] exp_addr;
    exp_en   = 8'b0101_0101;
    exp_dack = 8'b0010_0010;
    exp_iack = 8'b1000_1000;
    i_req = 1'b1;
    i_addr = 32'h20;
    d_req = 1'b1;
    d_we = 1'b0;
    d_addr = 32'h100;
    for (int k = 0; k < 8; k++) begin
      tick();
      n_cmp++;
      if ({mem_en, d_ack, i_ack} !== {exp_en[k], exp_dack[k], exp_iack[k]}) begin
        n_fail++;
        $display("FAIL b2b_cycle%0d: got {en,d_ack,i_ack}=%b want %b", k,
                 {mem_en, d_ack, i_ack}, {exp_en[k], exp_dack[k], exp_iack[k]});
      end
      if (exp_en[k]) begin
        exp_addr = ((k % 4) == 0) ? 32'h100 : 32'h20;
        n_cmp++;
        if (mem_addr !== exp_addr) begin
          n_fail++;
          $display("FAIL b2b_addr%0d: got %h want %h", k, mem_addr, exp_addr);
        end
      end
    end
    i_req = 1'b0;
    d_req = 1'b0;
    tick();
    n_cmp++;
    if ({mem_en, d_ack, i_ack} !== 3'b000) begin
      n_fail++;
      $display("FAIL b2b_idle: got {en,d_ack,i_ack}=%b want 000", {mem_en, d_ack, i_ack});
    end
  endtask

  initial begin
    for (int a = 0; a < 256; a++) mem[a] = 32'h0;
    mem[8'h04] = 32'hDEADBEEF;
    mem[8'h08] = 32'hA5A50020;
    mem[8'h10] = 32'hFFFFFFFF;
    mem[8'h40] = 32'hCAFE0100;
    test_reset();
    test_fetch();
    test_simultaneous();
    test_write();
    test_drop_and_wait();
    test_reset_mid();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
